osc_reset_sequencer: RTL and testbench
======================================

Name: osc_reset_sequencer

Overview:
- Sits directly downstream of the board reset synchroniser.
- Consumes its synchronous active-low system reset and releases the oscilloscope's per-subsystem resets in a fixed order: ADC front-end, then capture buffer, then display/VGA.
- Handshakes with ADC init-done, applies a timeout and a bounded retry, and reports sequence state.

Parameters:
- HOLD_CYCLES, 1200, cycles all resets stay asserted after sync_resetn_i goes high (100 us at 12 MHz); must be >=1.
- STAGE_GAP, 16, cycles between consecutive stage releases and the FAULT back-off length; must be >=1.
- ADC_TIMEOUT, 12000, cycles allowed for adc_init_done_i after adc_rstn_o release; must be >=1.
- MAX_RETRY, 3, ADC re-release attempts before lockout.

Ports:
- clk_i  input  1  12 MHz system clock (BUFG).
- internal_rst_En  input  1  asynchronous, active-high reset; clock clk_i.
- sync_resetn_i  input  1  synchronous active-low system reset from the reset synchroniser.
- adc_init_done_i  input  1  ADC front-end init complete; asynchronous level.
- adc_rstn_o  output  1  ADC interface reset, active-low.
- capture_rstn_o  output  1  capture buffer reset, active-low.
- display_rstn_o  output  1  display pipeline reset, active-low.
- sys_ready_o  output  1  all stages released.
- timeout_err_o  output  1  sticky ADC init failure flag.
- state_o  output  3  current FSM state encoding.

Behaviour:
- All outputs are registered.
- Reset (internal_rst_En=1, async):
  - state=RESET; all *_rstn_o=0; sys_ready_o=0; timeout_err_o=0.
  - Counters, retry_cnt and the done synchroniser cleared.
- adc_init_done_i passes through a 2-flop synchroniser (done_s) before use.
- State encoding: RESET=0, HOLD=1, ADC_WAIT=2, CAP_GAP=3, DISP_GAP=4, RUN=5, FAULT=6, LOCKOUT=7.
- Global override: in any state, sync_resetn_i sampled 0 forces the following at that same edge:
  - state=RESET; all *_rstn_o=0; sys_ready_o=0; cnt=0; retry_cnt=0.
  - timeout_err_o is unaffected; only internal_rst_En clears it.
- RESET: sync_resetn_i=1 at edge E0 -> HOLD, cnt=0.
- HOLD: cnt increments each edge. At the edge where cnt==HOLD_CYCLES-1 -> ADC_WAIT, adc_rstn_o<=1, cnt=0. adc_rstn_o therefore rises exactly HOLD_CYCLES edges after E0.
- ADC_WAIT:
  - done_s=1 -> CAP_GAP, cnt=0 (done takes priority if both occur on the same edge).
  - Otherwise, at cnt==ADC_TIMEOUT-1 -> FAULT, adc_rstn_o<=0, retry_cnt+1, cnt=0.
  - Otherwise cnt+1.
- CAP_GAP: at cnt==STAGE_GAP-1 -> DISP_GAP, capture_rstn_o<=1, cnt=0.
- DISP_GAP: at cnt==STAGE_GAP-1 -> RUN, display_rstn_o<=1, sys_ready_o<=1.
- RUN:
  - Holds all released.
  - done_s deasserting is ignored.
  - Exit only via the global override.
- FAULT:
  - adc_rstn_o held 0 for STAGE_GAP cycles.
  - Then, if retry_cnt<=MAX_RETRY -> ADC_WAIT, adc_rstn_o<=1, cnt=0.
  - Else -> LOCKOUT, timeout_err_o<=1.
- LOCKOUT:
  - All resets remain asserted; timeout_err_o=1.
  - Exit only via the global override (then re-sequences with error still flagged) or internal_rst_En.
- Counter widths: sized for the largest of HOLD_CYCLES, STAGE_GAP and ADC_TIMEOUT; no wrap inside a state.
- Release order is invariant: capture_rstn_o never 1 while adc_rstn_o=0; display_rstn_o never 1 while capture_rstn_o=0.
- Reset mid-operation:
  - Assertion of internal_rst_En or sync_resetn_i=0 during any gap or wait aborts immediately.
  - No partial stage stays released.

Test Plan:
- Nominal sequence (HOLD_CYCLES=8, STAGE_GAP=4, ADC_TIMEOUT=50): internal_rst_En pulse, sync_resetn_i high at E0, adc_init_done_i high 5 cycles after adc release.
  - adc_rstn_o rises at E0+8.
  - capture_rstn_o rises 2 (sync) + 1 + 4 edges after done.
  - display_rstn_o and sys_ready_o rise 4 edges later.
  - state_o ends at 5.
- Timeout and recovery (same parameters): done held 0.
  - At adc_release+50 edges: state_o=6, adc_rstn_o=0.
  - 4 edges later adc_rstn_o=1 again.
  - Raise done on the 2nd attempt -> reaches RUN with timeout_err_o=0.
- Lockout (MAX_RETRY=3): done held 0.
  - Exactly 4 adc_rstn_o release pulses.
  - Then state_o=7, timeout_err_o=1, all resets 0.
  - sync_resetn_i low/high restarts HOLD with timeout_err_o still 1.
- Mid-sequence abort: drop sync_resetn_i for 1 cycle while in CAP_GAP.
  - Next edge: state_o=0, all *_rstn_o=0, sys_ready_o=0.
  - Full sequence replays with identical latencies.
- Async reset: assert internal_rst_En between clock edges while in RUN.
  - All outputs 0 without waiting for a clock edge.
  - timeout_err_o cleared.
- Ordering check: random done jitter and random sync_resetn_i drops over 10k cycles.
  - Assertion holds that release order is never violated.
  - sys_ready_o=1 only when all three resets are 1.

Source files
------------

// File: rtl/osc_reset_sequencer_if.sv
// Reset-sequencer bundle: upstream sync reset and ADC handshake in, ordered stage resets and status out.
interface osc_reset_sequencer_if;
  logic       sync_resetn_i;
  logic       adc_init_done_i;
  logic       adc_rstn_o;
  logic       capture_rstn_o;
  logic       display_rstn_o;
  logic       sys_ready_o;
  logic       timeout_err_o;
  logic [2:0] state_o;

  modport master (
    output sync_resetn_i, adc_init_done_i,
    input  adc_rstn_o, capture_rstn_o, display_rstn_o, sys_ready_o, timeout_err_o, state_o
  );

  modport slave (
    input  sync_resetn_i, adc_init_done_i,
    output adc_rstn_o, capture_rstn_o, display_rstn_o, sys_ready_o, timeout_err_o, state_o
  );
endinterface

// File: rtl/osc_reset_sequencer.sv
// Releases ADC, capture and display resets in order after the system reset lifts,
// with ADC init-done timeout, bounded retry and a sticky lockout flag.
module osc_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1200,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned ADC_TIMEOUT = 12000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                  clk_i,
  input  logic                  internal_rst_En,
  osc_reset_sequencer_if.slave  bus
);

  localparam int unsigned MAX_HS  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CNT_MAX = (MAX_HS > ADC_TIMEOUT) ? MAX_HS : ADC_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_HOLD     = 3'd1,
    ST_ADC_WAIT = 3'd2,
    ST_CAP_GAP  = 3'd3,
    ST_DISP_GAP = 3'd4,
    ST_RUN      = 3'd5,
    ST_FAULT    = 3'd6,
    ST_LOCKOUT  = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 adc_q, adc_d;
  logic                 cap_q, cap_d;
  logic                 disp_q, disp_d;
  logic                 rdy_q, rdy_d;
  logic                 err_q, err_d;
  logic                 done_meta, done_s;

  // Two-flop synchroniser for the asynchronous ADC init-done level
  always_ff @(posedge clk_i or posedge internal_rst_En) begin
    if (internal_rst_En) begin
      done_meta <= 1'b0;
      done_s    <= 1'b0;
    end else begin
      done_meta <= bus.adc_init_done_i;
      done_s    <= done_meta;
    end
  end

  always_ff @(posedge clk_i or posedge internal_rst_En) begin
    if (internal_rst_En) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      retry_q <= '0;
      adc_q   <= 1'b0;
      cap_q   <= 1'b0;
      disp_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      adc_q   <= adc_d;
      cap_q   <= cap_d;
      disp_q  <= disp_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    adc_d   = adc_q;
    cap_d   = cap_q;
    disp_d  = disp_q;
    rdy_d   = rdy_q;
    err_d   = err_q;

    case (state_q)
      ST_RESET: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_ADC_WAIT;
          adc_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ADC_WAIT: begin
        if (done_s) begin
          state_d = ST_CAP_GAP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(ADC_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
          adc_d   = 1'b0;
          retry_d = retry_q + RETRY_W'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAP_GAP: begin
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          state_d = ST_DISP_GAP;
          cap_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DISP_GAP: begin
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          state_d = ST_RUN;
          disp_d  = 1'b1;
          rdy_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          if (retry_q <= RETRY_W'(MAX_RETRY)) begin
            state_d = ST_ADC_WAIT;
            adc_d   = 1'b1;
          end else begin
            state_d = ST_LOCKOUT;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // Upstream reset wins from any state; the error flag survives it
    if (!bus.sync_resetn_i) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
      adc_d   = 1'b0;
      cap_d   = 1'b0;
      disp_d  = 1'b0;
      rdy_d   = 1'b0;
    end
  end

  assign bus.adc_rstn_o     = adc_q;
  assign bus.capture_rstn_o = cap_q;
  assign bus.display_rstn_o = disp_q;
  assign bus.sys_ready_o    = rdy_q;
  assign bus.timeout_err_o  = err_q;
  assign bus.state_o        = state_q;

endmodule

// File: tb/tb_osc_reset_sequencer.sv
// Directed checks of the reset release sequence, timeout/retry/lockout, aborts and ordering.
module tb_osc_reset_sequencer;

  logic clk = 1'b0;
  logic internal_rst_En;
  int   checks = 0;
  int   errors = 0;

  osc_reset_sequencer_if bus ();

  osc_reset_sequencer #(
    .HOLD_CYCLES (8),
    .STAGE_GAP   (4),
    .ADC_TIMEOUT (50),
    .MAX_RETRY   (3)
  ) dut (
    .clk_i           (clk),
    .internal_rst_En (internal_rst_En),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {bus.adc_rstn_o, bus.capture_rstn_o, bus.display_rstn_o,
            bus.sys_ready_o, bus.timeout_err_o};
  endfunction

  // Drop sync reset for one edge, then raise it; returns after E0 (state HOLD)
  task automatic restart();
    bus.sync_resetn_i = 1'b0;
    tick(1);
    chk("restart_state", 32'(bus.state_o), 0);
    bus.sync_resetn_i = 1'b1;
    tick(1);
    chk("restart_hold", 32'(bus.state_o), 1);
  endtask

  int   pulses;
  logic prev_adc;

  initial begin
    internal_rst_En     = 1'b1;
    bus.sync_resetn_i   = 1'b0;
    bus.adc_init_done_i = 1'b0;
    #12;
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_outs", 32'(outs()), 0);
    internal_rst_En = 1'b0;
    tick(2);
    chk("idle_state", 32'(bus.state_o), 0);

    // Nominal sequence
    bus.sync_resetn_i = 1'b1;
    tick(1);
    chk("nom_hold", 32'(bus.state_o), 1);
    tick(7);
    chk("nom_adc_pre", 32'(bus.adc_rstn_o), 0);
    tick(1);
    chk("nom_adc_rise", 32'(bus.adc_rstn_o), 1);
    chk("nom_adc_wait", 32'(bus.state_o), 2);
    tick(5);
    bus.adc_init_done_i = 1'b1;
    tick(6);
    chk("nom_cap_pre", 32'(bus.capture_rstn_o), 0);
    chk("nom_cap_gap", 32'(bus.state_o), 3);
    tick(1);
    chk("nom_cap_rise", 32'(bus.capture_rstn_o), 1);
    chk("nom_disp_gap", 32'(bus.state_o), 4);
    tick(3);
    chk("nom_disp_pre", 32'(bus.display_rstn_o), 0);
    tick(1);
    chk("nom_run_outs", 32'(outs()), 5'b11110);
    chk("nom_run_state", 32'(bus.state_o), 5);
    bus.adc_init_done_i = 1'b0;
    tick(5);
    chk("run_ignores_done", 32'(bus.state_o), 5);

    // Timeout then recovery on the second attempt
    restart();
    tick(8);
    chk("to_adc_rise", 32'(bus.adc_rstn_o), 1);
    tick(49);
    chk("to_wait", 32'(bus.state_o), 2);
    tick(1);
    chk("to_fault", 32'(bus.state_o), 6);
    chk("to_adc_low", 32'(bus.adc_rstn_o), 0);
    tick(3);
    chk("to_backoff", 32'(bus.adc_rstn_o), 0);
    tick(1);
    chk("to_rerelease", 32'(bus.adc_rstn_o), 1);
    chk("to_rewait", 32'(bus.state_o), 2);
    bus.adc_init_done_i = 1'b1;
    tick(3);
    chk("to_cap_gap", 32'(bus.state_o), 3);
    tick(8);
    chk("to_run_state", 32'(bus.state_o), 5);
    chk("to_run_outs", 32'(outs()), 5'b11110);

    // Lockout after four failed releases
    bus.adc_init_done_i = 1'b0;
    restart();
    pulses   = 0;
    prev_adc = bus.adc_rstn_o;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (bus.adc_rstn_o && !prev_adc) pulses++;
      prev_adc = bus.adc_rstn_o;
      if (bus.state_o == 3'd7) break;
    end
    chk("lock_state", 32'(bus.state_o), 7);
    chk("lock_pulses", 32'(pulses), 4);
    chk("lock_outs", 32'(outs()), 5'b00001);
    tick(20);
    chk("lock_stays", 32'(bus.state_o), 7);
    bus.sync_resetn_i = 1'b0;
    tick(1);
    chk("lock_exit_state", 32'(bus.state_o), 0);
    chk("lock_exit_err", 32'(bus.timeout_err_o), 1);
    bus.sync_resetn_i = 1'b1;
    tick(1);
    chk("lock_rehold", 32'(bus.state_o), 1);
    chk("lock_rehold_err", 32'(bus.timeout_err_o), 1);

    // Mid-sequence abort in CAP_GAP, then identical replay
    bus.adc_init_done_i = 1'b1;
    restart();
    tick(8);
    chk("ab_adc_rise", 32'(bus.adc_rstn_o), 1);
    tick(1);
    chk("ab_cap_gap", 32'(bus.state_o), 3);
    tick(1);
    bus.sync_resetn_i = 1'b0;
    tick(1);
    chk("ab_state", 32'(bus.state_o), 0);
    chk("ab_outs", 32'(outs()), 5'b00001);
    bus.sync_resetn_i = 1'b1;
    tick(1);
    chk("ab_hold", 32'(bus.state_o), 1);
    tick(7);
    chk("ab_adc_pre", 32'(bus.adc_rstn_o), 0);
    tick(1);
    chk("ab_adc_rise2", 32'(bus.adc_rstn_o), 1);
    tick(1);
    chk("ab_cap_gap2", 32'(bus.state_o), 3);
    tick(3);
    chk("ab_cap_pre", 32'(bus.capture_rstn_o), 0);
    tick(1);
    chk("ab_cap_rise", 32'(bus.capture_rstn_o), 1);
    tick(4);
    chk("ab_run_outs", 32'(outs()), 5'b11111);

    // Asynchronous reset between edges while in RUN
    #2;
    internal_rst_En = 1'b1;
    #1;
    chk("async_outs", 32'(outs()), 0);
    chk("async_state", 32'(bus.state_o), 0);
    #1;
    internal_rst_En = 1'b0;
    tick(1);

    // Random done jitter and sync drops; release order must hold every cycle
    for (int i = 0; i < 10000; i++) begin
      bus.adc_init_done_i = ($urandom_range(0, 3) == 0);
      bus.sync_resetn_i   = ($urandom_range(0, 149) != 0);
      tick(1);
      chk("ord_cap_adc", 32'(bus.capture_rstn_o & ~bus.adc_rstn_o), 0);
      chk("ord_disp_cap", 32'(bus.display_rstn_o & ~bus.capture_rstn_o), 0);
      chk("ord_ready_all", 32'(bus.sys_ready_o &
          ~(bus.adc_rstn_o & bus.capture_rstn_o & bus.display_rstn_o)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
